drum_sequencer: RTL
===================

Name: drum_sequencer

Overview:
Parametrised step sequencer: NUM_INS instrument channels, each holding a STEPS-long on/off pattern, played back one step per tempo tick.
- Generalises the fixed 4-instrument / 8-step datapath.
- Adds an internal step counter, synchronous pattern loading, programmable pattern length, per-channel mute, a pause state and one-cycle trigger pulses.
- Sits between the control FSM (load strobes, select bus) and the bpm divider (tick) upstream, and the sound/LED outputs downstream.

Parameters:
NUM_INS, 4, number of instrument channels
STEP_W, 3, step index width; STEPS = 2**STEP_W pattern length (default 8)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
tick  input  1  one-clk-wide step strobe from the bpm divider
play  input  1  level; 1 = run, 0 = stop
pause  input  1  level; 1 = freeze at current step (only while play=1)
ld_ins  input  NUM_INS  per-channel pattern load strobes
ld_len  input  1  load pattern length
sel  input  STEPS  pattern data; bit i = hit on step i
len  input  STEP_W  last step index to load (pattern length - 1)
mute  input  NUM_INS  per-channel mute, level
ins_out  output  NUM_INS  gate: held from one played step to the next
trig  output  NUM_INS  one-clk pulse on each hit
step  output  STEP_W  index of the next step to play
running  output  1  1 when state == RUN

Behaviour:
- Reset: sampled at posedge clk while reset==0. Values after reset:
  - all patterns = 0
  - last_step = STEPS-1
  - step = 0
  - state = STOP
  - ins_out = 0, trig = 0, running = 0
- Reset overrides every other input in the same cycle.
- Loading:
  - Synchronous; accepted in any state.
  - ld_ins[i]=1 writes sel into pattern[i]. Multiple bits set load all selected channels with the same sel.
  - ld_len=1 writes len into last_step.
  - Load and tick in the same cycle: the tick uses the old pattern/length; the new values apply from the next tick.
- FSM states:
  - STOP:
    - step held at 0; ins_out = 0, trig = 0.
    - play=1 & pause=0 -> RUN.
    - play=1 & pause=1 -> PAUSE.
  - RUN:
    - On tick: for each i, ins_out[i] <= pattern[i][step] & ~mute[i], and trig[i] <= the same value for one clk.
    - step <= (step >= last_step) ? 0 : step+1. The >= handles a length shortened below the current step: wrap to 0.
    - No tick: ins_out holds, trig = 0.
    - play=0 -> STOP: step <= 0, ins_out <= 0, any tick that cycle ignored.
    - pause=1 -> PAUSE: ins_out <= 0, step held, tick ignored.
  - PAUSE:
    - Outputs 0; step held; ticks ignored.
    - play=0 -> STOP (step <= 0).
    - pause=0 -> RUN, resuming at the held step on the next tick.
- Latency: a tick sampled at edge k produces ins_out/trig after edge k. The first tick after entering RUN plays step 0.
- Mute is sampled only at tick time. Changing mute mid-step does not alter the held gate.
- last_step = 0: every tick plays step 0.
- running is registered and equals (state==RUN).

Test Plan:
- Reset then NUM_INS=4, STEP_W=3: load pattern[0]=8'b1010_0101, pattern[1]=8'hFF, play=1, 8 ticks -> ins_out[0] sequence 1,0,1,0,0,1,0,1; trig[1] pulses exactly 8 times, one clk each; step wraps 7->0.
- ld_len with len=2, pattern[0]=8'b0000_0110, 6 ticks -> ins_out[0] 0,1,1,0,1,1; step cycles 0,1,2.
- Running at step=6, ld_len len=3 -> next tick plays step 6, then step=0 (wrap via >=).
- pause=1 at step=4 for 3 ticks -> outputs 0, step stays 4; pause=0 then tick -> plays step 4. play=0 -> STOP, step=0, ins_out=0.
- mute[2]=1 with pattern[2]=8'hFF -> ins_out[2] and trig[2] stay 0. Clear mute between ticks -> gate unchanged until the next tick, then 1.
- ld_ins=4'b0011 coincident with tick -> the tick plays the old bits; the next step uses the new sel on channels 0 and 1. reset=0 mid-RUN -> all outputs 0 and patterns 0 after that edge.

Source files
------------

// File: rtl/drum_sequencer_if.sv
// Bundle between the sequencer and its neighbours. The control FSM and
// the bpm divider act as master. The sequencer core acts as slave.
interface drum_sequencer_if #(
  parameter int NUM_INS = 4,
  parameter int STEP_W  = 3
);
  localparam int STEPS = 2 ** STEP_W;

  // step strobe, transport and loading controls
  logic                tick;
  logic                play;
  logic                pause;
  logic [NUM_INS-1:0]  ld_ins;
  logic                ld_len;
  logic [STEPS-1:0]    sel;
  logic [STEP_W-1:0]   len;
  logic [NUM_INS-1:0]  mute;

  // playback outputs toward sound / LED logic
  logic [NUM_INS-1:0]  ins_out;
  logic [NUM_INS-1:0]  trig;
  logic [STEP_W-1:0]   step;
  logic                running;

  modport master (
    output tick, play, pause, ld_ins, ld_len, sel, len, mute,
    input  ins_out, trig, step, running
  );

  modport slave (
    input  tick, play, pause, ld_ins, ld_len, sel, len, mute,
    output ins_out, trig, step, running
  );
endinterface

// File: rtl/drum_sequencer.sv
// Step sequencer with NUM_INS channels and STEPS = 2**STEP_W steps each.
// It plays one step per tempo tick and drives a held gate per channel
// plus a one-clock trigger pulse on each hit. Patterns and the pattern
// length load synchronously in any state. A tick in the same cycle
// still plays the old values.
module drum_sequencer #(
  parameter int NUM_INS = 4,
  parameter int STEP_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  drum_sequencer_if.slave     bus
);
  localparam int STEPS = 2 ** STEP_W;

  typedef enum logic [1:0] {
    S_STOP  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t               state_q;
  logic [STEP_W-1:0]    step_q;
  logic [NUM_INS-1:0]   ins_q;
  logic [NUM_INS-1:0]   trig_q;
  logic                 run_q;

  logic [STEPS-1:0]     pat_q [NUM_INS];
  logic [STEPS-1:0]     pat_d [NUM_INS];
  logic [STEP_W-1:0]    last_q;
  logic [STEP_W-1:0]    last_d;

  logic [NUM_INS-1:0]   hit;
  logic [STEP_W-1:0]    step_nxt;

  // Next pattern/length values. The registers update at the edge, so a
  // coincident tick still reads the old contents.
  always_comb begin
    for (int i = 0; i < NUM_INS; i++) begin
      pat_d[i] = pat_q[i];
      if (bus.ld_ins[i]) pat_d[i] = bus.sel;
    end
    last_d = last_q;
    if (bus.ld_len) last_d = bus.len;
  end

  // Pattern and length storage, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INS; i++) pat_q[i] <= '0;
      last_q <= STEP_W'(STEPS - 1);
    end else begin
      for (int i = 0; i < NUM_INS; i++) pat_q[i] <= pat_d[i];
      last_q <= last_d;
    end
  end

  // Hit vector for the current step with mute applied. It is captured
  // only on a tick, so a mute change between ticks leaves the gate alone.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_INS; i++) begin
      hit[i] = pat_q[i][step_q] & ~bus.mute[i];
    end
    // >= instead of == so a length shortened below the current step wraps
    step_nxt = (step_q >= last_q) ? '0 : step_q + 1'b1;
  end

  // Transport FSM with registered gate, trigger, step and running outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_STOP;
      step_q  <= '0;
      ins_q   <= '0;
      trig_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      trig_q <= '0;
      unique case (state_q)
        S_STOP: begin
          ins_q  <= '0;
          step_q <= '0;
          if (bus.play) begin
            if (bus.pause) begin
              state_q <= S_PAUSE;
            end else begin
              state_q <= S_RUN;
              run_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!bus.play) begin
            state_q <= S_STOP;
            step_q  <= '0;
            ins_q   <= '0;
            run_q   <= 1'b0;
          end else if (bus.pause) begin
            state_q <= S_PAUSE;
            ins_q   <= '0;
            run_q   <= 1'b0;
          end else if (bus.tick) begin
            ins_q  <= hit;
            trig_q <= hit;
            step_q <= step_nxt;
          end
        end
        S_PAUSE: begin
          ins_q <= '0;
          if (!bus.play) begin
            state_q <= S_STOP;
            step_q  <= '0;
          end else if (!bus.pause) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_STOP;
          step_q  <= '0;
          ins_q   <= '0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ins_out = ins_q;
  assign bus.trig    = trig_q;
  assign bus.step    = step_q;
  assign bus.running = run_q;

endmodule
